// File: rtl/slave_out_port.sv
// rtl/slave_out_port.sv - serial read-response burst transmitter (optional underrun flag: SLAVE_OUT_UNDERRUN_EN)
module slave_out_port #(
  parameter int WORD_SIZE  = 8,
  parameter int BURST_SIZE = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            instruction,
  input  logic [BURST_SIZE-1:0] burst_size,
  input  logic [WORD_SIZE-1:0]  tx_word,
  input  logic                  word_valid,
  output logic                  word_ack,
  input  logic                  m_ready,
  output logic                  s_valid,
  output logic                  tx_data,
  output logic                  tx_done,
  output logic                  busy,
  output logic                  underrun
);

  localparam int BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [BW-1:0]         LAST_BIT = BW'(WORD_SIZE - 1);
  localparam logic [BW-1:0]         PRE_LAST = BW'(WORD_SIZE - 2);
  localparam logic [BURST_SIZE-1:0] ONE_WORD = BURST_SIZE'(1);

  typedef enum logic [1:0] {IDLE, LOAD, HANDSHAKE, SEND} state_t;

  state_t                state, state_d;
  logic [BURST_SIZE-1:0] word_cnt, word_cnt_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic [WORD_SIZE-1:0]  shreg, shreg_d;
  logic [WORD_SIZE-1:0]  next_word, next_word_d;
  logic                  s_valid_d, tx_data_d, word_ack_d, tx_done_d, busy_d;
  logic                  start_cmd;

  assign start_cmd = (instruction == 3'b001) || (instruction == 3'b011);

`ifdef SLAVE_OUT_UNDERRUN_EN
  logic underrun_ev;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d     = state;
    word_cnt_d  = word_cnt;
    bit_cnt_d   = bit_cnt;
    shreg_d     = shreg;
    next_word_d = next_word;
    s_valid_d   = 1'b0;
    tx_data_d   = 1'b0;
    word_ack_d  = 1'b0;
    tx_done_d   = 1'b0;
`ifdef SLAVE_OUT_UNDERRUN_EN
    underrun_ev = 1'b0;
`endif
    case (state)
      IDLE: begin
        // The tx_done cycle is a mandatory idle cycle: commands seen then are dropped.
        if (start_cmd && !tx_done) begin
          word_cnt_d = (burst_size == '0) ? ONE_WORD : burst_size;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (word_valid) begin
          shreg_d    = tx_word;
          word_ack_d = 1'b1;
          s_valid_d  = 1'b1;
          state_d    = HANDSHAKE;
        end
      end
      HANDSHAKE: begin
        s_valid_d = 1'b1;
        if (m_ready) begin
          s_valid_d = 1'b0;
          tx_data_d = shreg[0];
          shreg_d   = shreg >> 1;
          bit_cnt_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bit_cnt == LAST_BIT) begin
          if (word_cnt == ONE_WORD) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            // Next word's bit 0 follows immediately, no new handshake.
            word_cnt_d = word_cnt - ONE_WORD;
            tx_data_d  = next_word[0];
            shreg_d    = next_word >> 1;
            bit_cnt_d  = '0;
          end
        end else begin
          tx_data_d = shreg[0];
          shreg_d   = shreg >> 1;
          bit_cnt_d = bit_cnt + 1'b1;
          // Prefetch the following word one bit early so the burst stays contiguous.
          if ((bit_cnt == PRE_LAST) && (word_cnt != ONE_WORD)) begin
            if (word_valid) begin
              next_word_d = tx_word;
              word_ack_d  = 1'b1;
            end else begin
              next_word_d = '0;
`ifdef SLAVE_OUT_UNDERRUN_EN
              underrun_ev = 1'b1;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      next_word <= '0;
      s_valid   <= 1'b0;
      tx_data   <= 1'b0;
      word_ack  <= 1'b0;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      word_cnt  <= word_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      next_word <= next_word_d;
      s_valid   <= s_valid_d;
      tx_data   <= tx_data_d;
      word_ack  <= word_ack_d;
      tx_done   <= tx_done_d;
      busy      <= busy_d;
    end
  end

`ifdef SLAVE_OUT_UNDERRUN_EN
  // Sticky underrun flag, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              underrun <= 1'b0;
    else if (underrun_ev) underrun <= 1'b1;
  end
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_slave_out_port.sv
// tb/tb_slave_out_port.sv - scoreboard bench for slave_out_port
module tb_slave_out_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  instruction = 3'b000;
  logic [14:0] burst_size = 15'd0;
  logic [7:0]  tx_word = 8'h00;
  logic        word_valid = 1'b0;
  logic        word_ack;
  logic        m_ready = 1'b1;
  logic        s_valid;
  logic        tx_data;
  logic        tx_done;
  logic        busy;
  logic        underrun;

`ifdef SLAVE_OUT_UNDERRUN_EN
  localparam logic UNDER_EN = 1'b1;
`else
  localparam logic UNDER_EN = 1'b0;
`endif

  slave_out_port #(.WORD_SIZE(8), .BURST_SIZE(15)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .burst_size(burst_size),
    .tx_word(tx_word), .word_valid(word_valid), .word_ack(word_ack),
    .m_ready(m_ready), .s_valid(s_valid), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   exp_q[$];
  int   done_cnt = 0;
  int   ack_cnt = 0;
  logic [7:0] core_words [4];
  int   core_n = 0;
  int   core_idx = 0;
  bit   armed = 0;
  bit   streaming = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected bit per cycle after each handshake.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        armed = 0;
        streaming = 0;
      end else begin
        if (armed) begin
          streaming = 1;
          armed = 0;
        end
        if (tx_done) done_cnt++;
        if (streaming) begin
          if (tx_done) begin
            streaming = 0;
            check("bits_left_at_done", exp_q.size(), 0);
          end else begin
            check("bit_queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("tx_data_bit", tx_data, exp_q.pop_front());
            check("s_valid_low_in_send", s_valid, 0);
          end
        end
        if (s_valid && m_ready && !streaming) armed = 1;
        if (word_ack) ack_cnt++;
      end
    end
  endtask

  // Slave core model: offers words in order, advancing on word_ack.
  task automatic core_loop();
    forever begin
      @(negedge clk);
      if (!busy) core_idx = 0;
      else if (word_ack) core_idx++;
      word_valid = (core_idx < core_n);
      tx_word    = (core_idx < 4) ? core_words[core_idx] : 8'h00;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after tx_done.
  task automatic run_burst(input string tag, input logic [2:0] ins, input logic [14:0] bs,
                           input int nw, input int nvalid, input int stall, input bit hold);
    int d0, a0, c, exp_acks;
    core_n = nvalid;
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < 8; b++)
        exp_q.push_back((w < nvalid) ? core_words[w][b] : 1'b0);
    d0 = done_cnt;
    a0 = ack_cnt;
    exp_acks = (nvalid < nw) ? nvalid : nw;
    if (stall > 0) m_ready = 1'b0;
    instruction = ins;
    burst_size  = bs;
    @(posedge clk); #1;
    check({tag, "_busy_start"}, busy, 1);
    if (!hold) begin
      instruction = 3'b000;
      burst_size  = 15'h7fff;
    end
    if (stall > 0) begin
      c = 0;
      while (!s_valid && c < 50) begin @(negedge clk); c++; end
      check({tag, "_s_valid_rise"}, s_valid, 1);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({tag, "_stall_s_valid"}, s_valid, 1);
        check({tag, "_stall_tx_data"}, tx_data, 0);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
    end
    c = 0;
    while (done_cnt == d0 && c < 400) begin @(posedge clk); #1; c++; end
    check({tag, "_tx_done_count"}, done_cnt - d0, 1);
    check({tag, "_word_ack_count"}, ack_cnt - a0, exp_acks);
    check({tag, "_busy_end"}, busy, 0);
    instruction = 3'b000;
  endtask

  initial begin
    int c;
    fork
      monitor_loop();
      core_loop();
    join_none

    repeat (2) @(negedge clk);
    check("rst_s_valid", s_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_word_ack", word_ack, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_underrun", underrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single A5 word; instruction held high through tx_done must not restart.
    core_words = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_burst("a5", 3'b001, 15'd1, 1, 1, 0, 1'b1);

    core_words = '{8'h01, 8'h80, 8'hFF, 8'h00};
    run_burst("three", 3'b011, 15'd3, 3, 3, 0, 1'b0);

    core_words = '{8'h3C, 8'h00, 8'h00, 8'h00};
    run_burst("stall", 3'b001, 15'd1, 1, 1, 10, 1'b0);

    core_words = '{8'h5A, 8'h77, 8'h00, 8'h00};
    run_burst("under", 3'b001, 15'd2, 2, 1, 0, 1'b0);
    check("underrun_after_starve", underrun, UNDER_EN);

    core_words = '{8'hC3, 8'h00, 8'h00, 8'h00};
    run_burst("bsz0", 3'b001, 15'd0, 1, 1, 0, 1'b0);
    check("underrun_sticky", underrun, UNDER_EN);

    instruction = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ins010_busy", busy, 0);
      check("ins010_s_valid", s_valid, 0);
    end
    @(posedge clk); #1;
    instruction = 3'b000;

    // Reset asserted during bit 3 of an all-ones word.
    core_words = '{8'hFF, 8'h00, 8'h00, 8'h00};
    core_n = 1;
    for (int b = 0; b < 8; b++) exp_q.push_back(1'b1);
    instruction = 3'b001;
    burst_size  = 15'd1;
    @(posedge clk); #1;
    instruction = 3'b000;
    c = 0;
    while (!s_valid && c < 50) begin @(negedge clk); c++; end
    check("midrst_handshake", s_valid, 1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_s_valid", s_valid, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_underrun", underrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();

    core_words = '{8'h96, 8'h00, 8'h00, 8'h00};
    run_burst("post_rst", 3'b001, 15'd1, 1, 1, 0, 1'b0);
    check("post_rst_underrun", underrun, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
